// File: rtl/seq_function_unit_if.sv
// Operand/request and registered result/status bundle for seq_function_unit.
// master drives the request side; slave is the function unit.
interface seq_function_unit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       FS;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             V;
    logic             C;
    logic             N;
    logic             Z;

    modport master (
        output start, FS, OpA, OpB,
        input  busy, done, result, V, C, N, Z
    );

    modport slave (
        input  start, FS, OpA, OpB,
        output busy, done, result, V, C, N, Z
    );
endinterface

// File: rtl/seq_function_unit.sv
// Clocked function unit: logic/add ops latency 1, shift-add MUL and optional divider (FUNIT_DIV_EN) latency WIDTH+1.
// No backpressure: start is ignored while busy; result/flags hold until the next done pulse.
module seq_function_unit #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    seq_function_unit_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] TWO  = WIDTH'(2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [2*WIDTH-1:0] work, work_nxt;
    logic [WIDTH-1:0]   a_q, a_nxt;
    logic [WIDTH-1:0]   res_q, r_res;
    logic               v_q, c_q, n_q, z_q, done_q;
    logic               r_v, r_c, upd;

    logic [WIDTH-1:0]   add_x, add_y;
    logic               add_ci;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;

`ifdef FUNIT_DIV_EN
    logic [WIDTH-1:0]   b_q, b_nxt;
    logic               run_div, div_nxt, run_mod, mod_nxt;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] div_step;
`endif

    // Operand shaping for the five adder codes; only used in IDLE.
    always_comb begin
        add_x  = bus.OpA;
        add_y  = bus.OpB;
        add_ci = 1'b0;
        case (bus.FS)
            4'h9: begin add_y = ~bus.OpB; add_ci = 1'b1; end
            4'hA: begin add_x = bus.OpB; add_y = '0; add_ci = 1'b1; end
            4'hB: add_y = TWO;
            4'hC: begin add_x = ~bus.OpB; add_y = '0; add_ci = 1'b1; end
            default: ;
        endcase
        add_full = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};
    end

    // work = {accumulator, multiplier}; low bit of multiplier selects the partial product.
    always_comb begin
        mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        mul_step = {mul_sum, work[WIDTH-1:1]};
    end

`ifdef FUNIT_DIV_EN
    // Restoring division: work = {remainder, dividend/quotient}.
    always_comb begin
        div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
        div_step  = div_diff[WIDTH+1] ? {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0],  work[WIDTH-2:0], 1'b1};
    end
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        work_nxt  = work;
        a_nxt     = a_q;
        r_res     = '0;
        r_v       = 1'b0;
        r_c       = 1'b0;
        upd       = 1'b0;
`ifdef FUNIT_DIV_EN
        b_nxt     = b_q;
        div_nxt   = run_div;
        mod_nxt   = run_mod;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    a_nxt = bus.OpA;
`ifdef FUNIT_DIV_EN
                    b_nxt = bus.OpB;
`endif
                    upd   = 1'b1;
                    case (bus.FS)
                        4'h0: r_res = bus.OpA;
                        4'h1: r_res = ~bus.OpA;
                        4'h2: r_res = ~bus.OpB;
                        4'h3: r_res = bus.OpA & bus.OpB;
                        4'h4: r_res = ~(bus.OpA & bus.OpB);
                        4'h5: r_res = bus.OpA | bus.OpB;
                        4'h6: begin
                            upd       = 1'b0;
                            state_nxt = RUN;
                            cnt_nxt   = '0;
                            work_nxt  = {{WIDTH{1'b0}}, bus.OpB};
`ifdef FUNIT_DIV_EN
                            div_nxt   = 1'b0;
                            mod_nxt   = 1'b0;
`endif
                        end
                        4'h7: r_res[3:0] = bus.OpB[3:0];
                        4'h8, 4'h9, 4'hA, 4'hB, 4'hC: begin
                            r_res = add_full[WIDTH-1:0];
                            r_c   = add_full[WIDTH];
                            // carry into MSB recovered as x^y^sum at that bit
                            r_v   = add_x[WIDTH-1] ^ add_y[WIDTH-1] ^ add_full[WIDTH-1] ^ add_full[WIDTH];
                        end
`ifdef FUNIT_DIV_EN
                        4'hD, 4'hE: begin
                            if (bus.OpB == '0) begin
                                r_v   = 1'b1;
                                r_res = (bus.FS == 4'hD) ? {WIDTH{1'b1}} : bus.OpA;
                            end else begin
                                upd       = 1'b0;
                                state_nxt = RUN;
                                cnt_nxt   = '0;
                                work_nxt  = {{WIDTH{1'b0}}, bus.OpA};
                                div_nxt   = 1'b1;
                                mod_nxt   = (bus.FS == 4'hE);
                            end
                        end
`endif
                        default: r_res = '0;
                    endcase
                end
            end
            RUN: begin
                cnt_nxt  = cnt + CW'(1);
                work_nxt = mul_step;
`ifdef FUNIT_DIV_EN
                if (run_div) work_nxt = div_step;
`endif
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    upd       = 1'b1;
                    r_res     = work_nxt[WIDTH-1:0];
                    r_c       = |work_nxt[2*WIDTH-1:WIDTH];
`ifdef FUNIT_DIV_EN
                    if (run_div) r_c = 1'b0;
                    if (run_mod) r_res = work_nxt[2*WIDTH-1:WIDTH];
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            work   <= '0;
            a_q    <= '0;
            res_q  <= '0;
            v_q    <= 1'b0;
            c_q    <= 1'b0;
            n_q    <= 1'b0;
            z_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            work   <= work_nxt;
            a_q    <= a_nxt;
            done_q <= upd;
            if (upd) begin
                res_q <= r_res;
                v_q   <= r_v;
                c_q   <= r_c;
                n_q   <= r_res[WIDTH-1];
                z_q   <= (r_res == '0);
            end
        end
    end

`ifdef FUNIT_DIV_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_q     <= '0;
            run_div <= 1'b0;
            run_mod <= 1'b0;
        end else begin
            b_q     <= b_nxt;
            run_div <= div_nxt;
            run_mod <= mod_nxt;
        end
    end
`endif

    assign bus.busy   = (state == RUN);
    assign bus.done   = done_q;
    assign bus.result = res_q;
    assign bus.V      = v_q;
    assign bus.C      = c_q;
    assign bus.N      = n_q;
    assign bus.Z      = z_q;
endmodule

// File: tb/tb_seq_function_unit.sv
// Scoreboard bench for seq_function_unit (WIDTH=8); divider cases follow FUNIT_DIV_EN.
module tb_seq_function_unit;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    seq_function_unit_if #(.WIDTH(W)) bus();
    seq_function_unit #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct {
        logic [3:0] fs;
        logic [7:0] res;
        logic       v;
        logic       c;
        int         lat;
        int         t0;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    logic [7:0] prev_res;
    logic [3:0] prev_flags;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic exp_t model(input logic [3:0] fs, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int p, s, ss, ci;
        logic [7:0] x, y;
        e.fs = fs; e.res = 8'h00; e.v = 1'b0; e.c = 1'b0; e.lat = 1; e.t0 = 0;
        x = a; y = b; ci = 0;
        case (fs)
            4'd0: e.res = a;
            4'd1: e.res = ~a;
            4'd2: e.res = ~b;
            4'd3: e.res = a & b;
            4'd4: e.res = ~(a & b);
            4'd5: e.res = a | b;
            4'd6: begin
                p = int'(a) * int'(b);
                e.res = p[7:0];
                e.c = (p > 255);
                e.lat = W + 1;
            end
            4'd7: e.res = {4'h0, b[3:0]};
            4'd8, 4'd9, 4'd10, 4'd11, 4'd12: begin
                case (fs)
                    4'd9:  begin y = ~b; ci = 1; end
                    4'd10: begin x = b; y = 8'h00; ci = 1; end
                    4'd11: y = 8'd2;
                    4'd12: begin x = ~b; y = 8'h00; ci = 1; end
                    default: ;
                endcase
                s  = int'(x) + int'(y) + ci;
                ss = int'($signed(x)) + int'($signed(y)) + ci;
                e.res = s[7:0];
                e.c = s[8];
                e.v = (ss > 127) || (ss < -128);
            end
`ifdef FUNIT_DIV_EN
            4'd13, 4'd14: begin
                if (b == 8'h00) begin
                    e.v = 1'b1;
                    e.res = (fs == 4'd13) ? 8'hFF : a;
                end else begin
                    e.res = (fs == 4'd13) ? a / b : a % b;
                    e.lat = W + 1;
                end
            end
`endif
            default: e.res = 8'h00;
        endcase
        return e;
    endfunction

    // Compare every done pulse against the head of the scoreboard; otherwise outputs must hold.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    got_e = sb.pop_front();
                    check("result", {24'h0, bus.result}, {24'h0, got_e.res});
                    check("flags_VCNZ", {28'h0, bus.V, bus.C, bus.N, bus.Z},
                          {28'h0, got_e.v, got_e.c, got_e.res[7], (got_e.res == 8'h00)});
                    check("latency", cyc - got_e.t0, got_e.lat);
                end
            end else begin
                check("hold", {20'h0, bus.result, bus.V, bus.C, bus.N, bus.Z},
                      {20'h0, prev_res, prev_flags});
            end
        end
        prev_res   = bus.result;
        prev_flags = {bus.V, bus.C, bus.N, bus.Z};
    end

    task automatic issue(input logic [3:0] fs, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e = model(fs, a, b);
        e.t0 = cyc;
        bus.start = 1'b1; bus.FS = fs; bus.OpA = a; bus.OpB = b;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bus.start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", sb.size(), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check(tag, {20'h0, bus.busy, bus.done, bus.result, bus.V, bus.C, bus.N, bus.Z}, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.start = 1'b0; bus.FS = 4'h0; bus.OpA = 8'h00; bus.OpB = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset_state");
        reset_n = 1'b1;
        @(posedge clk); #1;

        issue(4'h8, 8'h7F, 8'h01); idle(); drain();
        // back-to-back: second start held in the done cycle of the first
        issue(4'h9, 8'h05, 8'h05);
        issue(4'h1, 8'h0F, 8'h00);
        issue(4'h0, 8'h80, 8'h3C);
        issue(4'h2, 8'h12, 8'h3C);
        issue(4'h3, 8'hF0, 8'h3C);
        issue(4'h4, 8'hF0, 8'h3C);
        issue(4'h5, 8'h0F, 8'hA0);
        issue(4'h7, 8'hFF, 8'hAB);
        issue(4'hA, 8'h00, 8'h7F);
        issue(4'hB, 8'h7E, 8'h00);
        issue(4'hC, 8'h00, 8'h80);
        issue(4'hC, 8'h00, 8'h00);
        idle(); drain();

        issue(4'h6, 8'd15, 8'd17); idle();
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("busy_run", {31'h0, bus.busy}, 32'd1);
            if (i == 2) begin bus.start = 1'b1; bus.FS = 4'h0; bus.OpA = 8'h55; end
            if (i == 3) bus.start = 1'b0;
        end
        drain();
        check("busy_after", {31'h0, bus.busy}, 32'd0);
        issue(4'h6, 8'd16, 8'd32); idle(); drain();

        issue(4'hF, 8'hAA, 8'h00); idle(); drain();
`ifdef FUNIT_DIV_EN
        issue(4'hD, 8'd100, 8'd7); idle(); drain();
        issue(4'hE, 8'd100, 8'd7); idle(); drain();
        issue(4'hD, 8'd100, 8'd0); idle(); drain();
        issue(4'hE, 8'd100, 8'd0); idle(); drain();
`else
        issue(4'hD, 8'hAA, 8'h07); idle(); drain();
        issue(4'hE, 8'hAA, 8'h07); idle(); drain();
`endif

        // reset in the middle of a multiply: no done, everything cleared
        issue(4'h6, 8'd200, 8'd100); idle();
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check_reset_state("reset_abort");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        issue(4'h6, 8'd200, 8'd3); idle(); drain();

        for (int k = 0; k < 24; k++) begin
            logic [3:0] f;
            logic [7:0] a, b;
            f = 4'($urandom_range(0, 15));
            a = 8'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            issue(f, a, b); idle(); drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
